pn_result_bcd: RTL

- Sits directly downstream of the Polish-Notation evaluator.
- Captures each signed 32-bit result from the evaluator's out_valid/out stream into a small FIFO.
- Converts each result to sign plus 10-digit packed BCD using sequential double-dabble.
- Presents converted results one at a time on a valid/ready interface to the display/UART formatter.
- The evaluator has no backpressure, so this block absorbs whole result bursts (up to 4 results).

---
 rtl/pn_pkg.sv | 29 ++
 rtl/pn_dd_core.sv | 62 ++++++
 rtl/pn_result_bcd.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pn_pkg.sv
// Shared types and sizes for the Polish-Notation result path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: result width/digit constants, output FSM state enum,
// queued result entry struct and a saturating 2-bit increment helper.
package pn_pkg;

    localparam int PN_RES_W       = 32;
    localparam int PN_BCD_DIGITS  = 10;
    localparam int PN_MAX_RESULTS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } pn_state_t;

    typedef struct packed {
        logic                first;
        logic [1:0]          idx;
        logic [PN_RES_W-1:0] data;
    } pn_res_entry_t;

    function automatic logic [1:0] pn_sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

endpackage

// File: rtl/pn_dd_core.sv
// Iterative signed binary to sign + packed BCD converter (double-dabble).
// Latency: load edge, then W busy cycles; last is high during the final step.
// Backpressure: none; results stay on sign/bcd until the next load.
//
// Ports: clk, rst_n; load/din start a conversion; busy while stepping;
// last flags the cycle whose edge performs the final step; sign/bcd hold
// the result (bcd shows the partial value while busy).
module pn_dd_core #(
    parameter int W      = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [W-1:0]          din,
    output logic                  busy,
    output logic                  last,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(W);

    logic [W-1:0]        mag_q;
    logic [CW-1:0]       step_q;
    logic [4*DIGITS-1:0] adj;

    // Digits >= 5 get +3 so the following left shift carries into the next digit.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign last = busy && (step_q == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            sign   <= 1'b0;
            bcd    <= '0;
            mag_q  <= '0;
            step_q <= '0;
        end else if (load) begin
            busy   <= 1'b1;
            sign   <= din[W-1];
            // Unsigned W-bit negation: the most negative input maps to 2^(W-1).
            mag_q  <= din[W-1] ? (~din + W'(1)) : din;
            bcd    <= '0;
            step_q <= '0;
        end else if (busy) begin
            bcd    <= {adj[4*DIGITS-2:0], mag_q[W-1]};
            mag_q  <= {mag_q[W-2:0], 1'b0};
            step_q <= step_q + CW'(1);
            if (last)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/pn_result_bcd.sv
// Queues evaluator results, converts each to sign + BCD, presents them one at a time.
// Latency: push into idle empty block -> out_valid W+1 edges later; one result per W+1 cycles.
// Backpressure: out_valid/out_ready on output; input cannot stall, so overflow drops and sets ovf.
//
// Ports: clk, rst_n; in_valid/in_data from the evaluator; out_valid/out_ready
// handshake with out_sign, out_bcd, out_first, out_idx; ovf sticky drop flag.
module pn_result_bcd
    import pn_pkg::*;
#(
    parameter int DEPTH  = PN_MAX_RESULTS,
    parameter int W      = PN_RES_W,
    parameter int DIGITS = PN_BCD_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [W-1:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_first,
    output logic [1:0]          out_idx,
    output logic                ovf
);

    localparam int AW = $clog2(DEPTH);

    pn_res_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    pn_state_t     state_q, state_d;
    logic          dd_load, dd_busy, dd_last;

    logic          prev_vld;
    logic [1:0]    burst_cnt;
    logic [1:0]    tag_idx;
    logic          tag_first;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(DEPTH));

    // A pop frees a slot on the same edge, so a full FIFO still accepts then.
    assign push = in_valid && (!fifo_full || pop);

    // Burst position: a new run starts whenever the previous cycle had no strobe.
    assign tag_first = !prev_vld;
    assign tag_idx   = prev_vld ? burst_cnt : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_vld  <= 1'b0;
            burst_cnt <= 2'd0;
            ovf       <= 1'b0;
        end else begin
            prev_vld <= in_valid;
            if (push)
                burst_cnt <= pn_sat_inc2(tag_idx);
            else if (in_valid)
                burst_cnt <= tag_idx;   // dropped input does not advance the run
            if (in_valid && !push)
                ovf <= 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by count/pointers only.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{first: tag_first, idx: tag_idx, data: in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        dd_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    dd_load = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (dd_last)
                    state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        dd_load = 1'b1;
                        state_d = CONV;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == HOLD);

    // Tags travel beside the converter and are captured with the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_first <= 1'b0;
            out_idx   <= 2'd0;
        end else if (dd_load) begin
            out_first <= mem[rd_ptr].first;
            out_idx   <= mem[rd_ptr].idx;
        end
    end

    pn_dd_core #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_dd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dd_load),
        .din   (mem[rd_ptr].data),
        .busy  (dd_busy),
        .last  (dd_last),
        .sign  (out_sign),
        .bcd   (out_bcd)
    );

    logic unused_busy;
    assign unused_busy = dd_busy;

endmodule
